// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// -------------
// Multi-cycle control sequencer for the 8-bit CPU. Fetches one instruction
// word per instruction from instruction memory, holds it in the instruction
// register (IR), presents opcode/immediate to op_decode, pulses register-file
// write-back and resolves JMP / JNZ / HALT by updating the program counter.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   run        in   level; 1 = execute, 0 = stop at next instruction boundary
//   imem_req   out  fetch request, held until imem_ack
//   imem_addr  out  fetch address (pc while imem_req=1, else 0)
//   imem_ack   in   imem_data valid this cycle (only looked at in FETCH)
//   imem_data  in   instruction word: [7:4] opcode, [3:0] immediate
//   op         out  IR[7:4]
//   imm        out  IR[3:0]
//   alu_zero   in   ALU zero flag, used by JNZ in EXEC
//   reg_we     out  register-file write enable, one-cycle pulse in WB
//   retire     out  one-cycle pulse when an instruction completes
//   pc         out  current program counter
//   busy       out  1 in every state except IDLE and HALT
//   halted     out  1 in HALT
//   dbg_state  out  raw FSM state encoding, for checkers and debug
//
// Handshake: the fetch is a request/acknowledge pair. imem_req rises on entry
// to FETCH and stays high, with imem_addr stable, until the first cycle in
// which imem_ack=1 is sampled at a rising edge; imem_data is captured into IR
// on that same edge and imem_req drops the next cycle. imem_ack seen in any
// other state has no effect.

module cpu_sequencer #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [3:0]      op,
  output logic [3:0]      imm,
  input  logic            alu_zero,
  output logic            reg_we,
  output logic            retire,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [2:0]      dbg_state
);

  // Control opcodes; every other opcode is a datapath op that writes back.
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_JNZ  = 4'hD;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;

  logic [3:0]      ir_op;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] pc_inc;
  logic            is_ctrl;

  assign ir_op  = ir_q[7:4];
  assign pc_inc = pc_q + PC_ONE;   // wraps modulo 2^PC_W
  assign is_ctrl = (ir_op == OP_HALT) || (ir_op == OP_JMP) || (ir_op == OP_JNZ);

  // Jump target is the immediate zero-extended to the pc width.
  always_comb begin
    jmp_target      = '0;
    jmp_target[3:0] = ir_q[3:0];
  end

  // ---------------------------------------------------------------------
  // State, pc and IR registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      // run is deliberately not looked at here: once a fetch starts the
      // instruction always runs to completion.
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end

      // One settle cycle for op_decode and the ALU.
      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        case (ir_op)
          OP_HALT: begin
            state_d = S_HALT;
          end
          OP_JMP: begin
            pc_d    = jmp_target;
            state_d = run ? S_FETCH : S_IDLE;
          end
          OP_JNZ: begin
            pc_d    = alu_zero ? pc_inc : jmp_target;
            state_d = run ? S_FETCH : S_IDLE;
          end
          default: begin
            state_d = S_WB;
          end
        endcase
      end

      S_WB: begin
        pc_d    = pc_inc;
        state_d = run ? S_FETCH : S_IDLE;
      end

      // Only rst leaves HALT.
      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded purely from the registered state and IR, so each
  // pulse lasts exactly the one cycle spent in its state and rst removes
  // them immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    reg_we    = 1'b0;
    retire    = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        busy      = 1'b1;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy   = 1'b1;
        retire = is_ctrl;
      end
      S_WB: begin
        busy   = 1'b1;
        reg_we = 1'b1;
        retire = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign op        = ir_q[7:4];
  assign imm       = ir_q[3:0];
  assign pc        = pc_q;
  assign dbg_state = state_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit CPU. It fetches 8-bit instructions from instruction memory, holds them in an instruction register, and presents the opcode to `op_decode`. It pulses register-file write-back and resolves jumps and halt by updating the program counter. It sits between instruction memory and the `op_decode`/ALU/register-file datapath.

## Interface

- `PC_W`, 4, program counter / instruction address width; must be ≥ 4.

- `clk`  in  1  system clock, rising-edge active
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- `imem_req`  out  1  fetch request, held until acknowledged
- `imem_addr`  out  PC_W  fetch address (= pc while `imem_req`=1)
- `imem_ack`  in  1  memory has valid `imem_data` this cycle
- `imem_data`  in  8  instruction word: [7:4] opcode, [3:0] immediate
- `op`  out  4  IR[7:4], feeds `op_decode`
- `imm`  out  4  IR[3:0]
- `alu_zero`  in  1  ALU zero flag, sampled in EXEC
- `reg_we`  out  1  register-file write enable, one-cycle pulse
- `retire`  out  1  one-cycle pulse when an instruction completes
- `pc`  out  PC_W  current program counter
- `busy`  out  1  1 in every state except IDLE and HALT
- `halted`  out  1  1 in HALT

## Operation

- Reset (async, immediate): state=IDLE, pc=0, IR=0x00. All outputs 0; `op` and `imm` are 0.
- `op`/`imm` are driven from IR at all times and change only when IR loads.
- Control opcodes: 15=HALT, 14=JMP imm, 13=JNZ imm. All other opcodes are datapath ops and are written back.
- Jump target = zero-extended `imm` to PC_W bits.
- pc increment wraps modulo 2^PC_W (e.g. 15→0 at PC_W=4).
- States:
  - IDLE: if run=1, go to FETCH; otherwise stay.
  - FETCH: `imem_req`=1, `imem_addr`=pc. On `imem_ack`=1, IR←`imem_data` and go to DECODE. Otherwise stay with req and addr stable. `run` is ignored here.
  - DECODE: one cycle for `op_decode` to settle; go to EXEC.
  - EXEC: one cycle.
    - HALT: go to HALT (pc unchanged, `retire`=1).
    - JMP: pc←imm, `retire`=1.
    - JNZ: pc←imm if `alu_zero`=0, else pc←pc+1; `retire`=1.
    - After a jump: go to FETCH if run=1, else IDLE.
    - Other opcodes: go to WB.
  - WB: `reg_we`=1, `retire`=1, pc←pc+1. Go to FETCH if run=1, else IDLE.
  - HALT: `halted`=1, no requests; exit only via `rst`.
- Dropping `run` mid-instruction never aborts the instruction. `run` is sampled only at the instruction boundary (EXEC branch/halt or WB).
- `imem_ack` outside FETCH is ignored.
- `reg_we` and `retire` are combinational from state, so there are no duplicate pulses.

## Timing

- With zero-wait memory (ack in first FETCH cycle): non-branch instruction = 4 cycles (FETCH, DECODE, EXEC, WB); jump = 3 cycles.
- Each memory wait cycle adds 1 cycle in FETCH.
- IDLE→FETCH takes 1 cycle after run=1 is sampled.
- `reg_we` and `retire` are high in WB for exactly one cycle. pc shows the new value on the cycle after WB or EXEC (the next FETCH).
- `rst` asserted mid-FETCH drops `imem_req` in the same cycle, without waiting for a clock edge.
- The first fetch after reset release is from address 0.

## Test plan

- Reset: assert rst mid-FETCH → `imem_req`, `reg_we`, `retire`, `busy`, `halted` = 0 immediately; pc=0, op=0. Release with run=1 → next fetch at `imem_addr`=0.
- Linear program, zero-wait ROM {0x12, 0x23, 0x34}, run=1:
  - fetches at addr 0, 1, 2 spaced 4 cycles apart;
  - op = 1, 2, 3 in successive DECODE cycles;
  - `reg_we` pulses 3 times, one cycle each.
- Wait states: ack delayed 3 cycles on addr 0 → `imem_req`=1 and `imem_addr`=0 held for 4 cycles; instruction completes in 7 cycles.
- Branches:
  - 0xE5 at addr 3 → next fetch addr 5, no `reg_we`, 3-cycle instruction.
  - 0xD9 with `alu_zero`=0 → next fetch 9.
  - 0xD9 with `alu_zero`=1 → next fetch pc+1.
- Wrap: non-branch instruction at pc=15 (PC_W=4) → next fetch addr 0.
- Stop and halt:
  - run dropped during DECODE of 0x12 → WB still pulses `reg_we`, then IDLE with busy=0, and no fetch until run=1.
  - 0xF0 → halted=1 and `retire` pulse, then no `imem_req` for 20 cycles with run=1; rst clears halted.
